lcd_bus_scheduler: RTL and testbench

LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

---
 rtl/lcd_defs.sv | 55 +++++
 rtl/lcd_bus_scheduler.sv | 154 +++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_defs.sv
// Shared LCD bus definitions: controller command bytes, the idle bus word,
// and the scheduler state encoding.
package lcd_defs;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_LINE1      = 8'h80;
    localparam logic [7:0] CMD_LINE2      = 8'hC0;

    typedef struct packed {
        logic       rw;
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

    localparam lcd_word_t IDLE_WORD = '{rw: 1'b1, rs: 1'b1, data: 8'h02};

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_INIT_GAP = 3'd1,
        ST_CLEAR    = 3'd2,
        ST_CLR_GAP  = 3'd3,
        ST_PASS     = 3'd4,
        ST_NONE     = 3'd5
    } lcd_state_t;

    // Power-up command sequence, one byte per init step.
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY_MODE;
            2'd3:    cmd = CMD_CLEAR;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    function automatic lcd_word_t cmd_word(input logic [7:0] cmd);
        return '{rw: 1'b0, rs: 1'b0, data: cmd};
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    function automatic logic is_busy(input lcd_state_t st);
        return (st == ST_INIT) || (st == ST_INIT_GAP) ||
               (st == ST_CLEAR) || (st == ST_CLR_GAP);
    endfunction

endpackage

// File: rtl/lcd_bus_scheduler.sv
// Shares one character-LCD bus among four requesters: runs the controller
// init sequence, then passes the MODE-selected requester through, clearing the
// display whenever MODE changes.
module lcd_bus_scheduler
    import lcd_defs::*;
#(
    parameter int INIT_WAIT = 4,
    parameter int CLR_WAIT  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  MODE,
    input  logic [3:0]  RW_IN,
    input  logic [3:0]  RS_IN,
    input  logic [31:0] DATA_IN,
    output logic        LCD_E,
    output logic        LCD_RW,
    output logic        LCD_RS,
    output logic [7:0]  LCD_DATA,
    output logic [3:0]  GRANT,
    output logic        BUSY
);

    // The gap counter runs from WAIT-1 down to 0, so it never needs to hold WAIT itself.
    localparam int GAP_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);
    localparam logic [GAP_W-1:0] INIT_LOAD = GAP_W'(INIT_WAIT - 1);
    localparam logic [GAP_W-1:0] CLR_LOAD  = GAP_W'(CLR_WAIT - 1);

    lcd_state_t       state_r, state_s;
    logic [1:0]       step_r, step_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic [3:0]       prev_mode_r;
    lcd_word_t        word_r, word_s;
    logic             e_r;
    logic [3:0]       grant_r, grant_s;
    logic             busy_r;

    logic [1:0]       sel_s;
    logic             mode_valid_s;
    logic             mode_chg_s;
    lcd_word_t        req_word_s;

    assign sel_s        = MODE[1:0];
    assign mode_valid_s = (MODE[3:2] == 2'b00);
    assign mode_chg_s   = (MODE != prev_mode_r);

    // 4:1 requester select; unselected bytes never reach the output path.
    always_comb begin
        req_word_s.rw   = RW_IN[sel_s];
        req_word_s.rs   = RS_IN[sel_s];
        req_word_s.data = DATA_IN[{sel_s, 3'b000} +: 8];
    end

    // Next-state, counters and the bus word to register on the next edge.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        gap_s   = gap_r;
        word_s  = IDLE_WORD;
        grant_s = 4'b0000;
        case (state_r)
            ST_INIT: begin
                word_s  = cmd_word(init_cmd(step_r));
                state_s = ST_INIT_GAP;
                gap_s   = INIT_LOAD;
            end
            ST_INIT_GAP: begin
                if (gap_r != {GAP_W{1'b0}}) begin
                    gap_s = gap_r - GAP_W'(1);
                end else if (step_r == 2'd3) begin
                    step_s  = 2'd0;
                    state_s = mode_valid_s ? ST_PASS : ST_NONE;
                end else begin
                    step_s  = step_r + 2'd1;
                    state_s = ST_INIT;
                end
            end
            ST_CLEAR: begin
                word_s  = cmd_word(CMD_CLEAR);
                state_s = ST_CLR_GAP;
                gap_s   = CLR_LOAD;
            end
            ST_CLR_GAP: begin
                // A further MODE change restarts the full clear gap.
                if (mode_chg_s) begin
                    gap_s = CLR_LOAD;
                end else if (gap_r != {GAP_W{1'b0}}) begin
                    gap_s = gap_r - GAP_W'(1);
                end else begin
                    state_s = mode_valid_s ? ST_PASS : ST_NONE;
                end
            end
            ST_PASS: begin
                if (mode_chg_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    word_s  = req_word_s;
                    grant_s = onehot4(sel_s);
                end
            end
            ST_NONE: begin
                if (mode_chg_s) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_NONE;
                end
            end
            default: begin
                state_s = ST_INIT;
                step_s  = 2'd0;
                gap_s   = {GAP_W{1'b0}};
            end
        endcase
    end

    // FSM state, init step, gap counter and MODE history.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r     <= ST_INIT;
            step_r      <= 2'd0;
            gap_r       <= {GAP_W{1'b0}};
            prev_mode_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            step_r      <= step_s;
            gap_r       <= gap_s;
            prev_mode_r <= MODE;
        end
    end

    // Registered bus outputs; BUSY describes the state that produced the word.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word_r  <= IDLE_WORD;
            e_r     <= 1'b0;
            grant_r <= 4'b0000;
            busy_r  <= 1'b1;
        end else begin
            word_r  <= word_s;
            e_r     <= ~word_s.rw;
            grant_r <= grant_s;
            busy_r  <= is_busy(state_r);
        end
    end

    assign LCD_RW   = word_r.rw;
    assign LCD_RS   = word_r.rs;
    assign LCD_DATA = word_r.data;
    assign LCD_E    = e_r;
    assign GRANT    = grant_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler: expected bus words are queued as
// stimulus is applied and compared one per clock after the active edge.
module tb_lcd_bus_scheduler;

    logic        CLK;
    logic        RESET;
    logic [3:0]  MODE;
    logic [3:0]  RW_IN;
    logic [3:0]  RS_IN;
    logic [31:0] DATA_IN;
    logic        LCD_E;
    logic        LCD_RW;
    logic        LCD_RS;
    logic [7:0]  LCD_DATA;
    logic [3:0]  GRANT;
    logic        BUSY;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs;

    lcd_bus_scheduler #(.INIT_WAIT(4), .CLR_WAIT(2)) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .RW_IN(RW_IN), .RS_IN(RS_IN),
        .DATA_IN(DATA_IN), .LCD_E(LCD_E), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS),
        .LCD_DATA(LCD_DATA), .GRANT(GRANT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign obs = {LCD_RW, LCD_RS, LCD_DATA, LCD_E, GRANT, BUSY};

    // Expected observation: E is the inverse of RW by definition of the bus.
    function automatic logic [15:0] ev(input logic rw, input logic rs, input logic [7:0] d,
                                       input logic [3:0] g, input logic b);
        return {rw, rs, d, ~rw, g, b};
    endfunction

    localparam logic [15:0] IDLE_BUSY = 16'({1'b1, 1'b1, 8'h02, 1'b0, 4'b0000, 1'b1});
    localparam logic [15:0] IDLE_FREE = 16'({1'b1, 1'b1, 8'h02, 1'b0, 4'b0000, 1'b0});

    task automatic push_init();
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(ev(1'b0, 1'b0, cmds[k], 4'b0000, 1'b1));
            repeat (4) exp_q.push_back(IDLE_BUSY);
        end
    endtask

    task automatic set_default_requesters();
        DATA_IN = {8'hD3, 8'hC2, 8'hA1, 8'h57};
        RW_IN   = 4'b1010;
        RS_IN   = 4'b1001;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        MODE  = 4'd0;
        set_default_requesters();
        #2 RESET = 1'b0;
        #1;
        vec_cnt++;
        if (obs !== IDLE_BUSY) begin
            err_cnt++;
            $display("FAIL reset_async: got %h expected %h", obs, IDLE_BUSY);
        end
        repeat (2) @(posedge CLK);
        #1;
        vec_cnt++;
        if (obs !== IDLE_BUSY) begin
            err_cnt++;
            $display("FAIL reset_hold: got %h expected %h", obs, IDLE_BUSY);
        end
    endtask

    task automatic test_init();
        logic [15:0] e;
        MODE = 4'd0;
        #3 RESET = 1'b1;
        push_init();
        repeat (2) exp_q.push_back(ev(1'b0, 1'b1, 8'h57, 4'b0001, 1'b0));
        for (int i = 0; i < 22; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL init_seq cycle %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_pass_data();
        logic [15:0] e;
        logic [31:0] r;
        logic [31:0] r2;
        for (int i = 0; i < 8; i++) begin
            r  = $urandom;
            r2 = $urandom;
            DATA_IN   = {r2[23:0], r[7:0]};
            RS_IN     = {r2[26:24], r[8]};
            RW_IN     = {r2[29:27], r[9]};
            exp_q.push_back(ev(r[9], r[8], r[7:0], 4'b0001, 1'b0));
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL pass_data cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        set_default_requesters();
    endtask

    task automatic test_mode_switch();
        logic [15:0] e;
        MODE = 4'd2;
        exp_q.push_back(IDLE_FREE);
        exp_q.push_back(ev(1'b0, 1'b0, 8'h01, 4'b0000, 1'b1));
        repeat (2) exp_q.push_back(IDLE_BUSY);
        repeat (2) exp_q.push_back(ev(1'b0, 1'b0, 8'hC2, 4'b0100, 1'b0));
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL mode_switch cycle %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_none();
        logic [15:0] e;
        MODE = 4'b1001;
        #2 RESET = 1'b0;
        #1 RESET = 1'b1;
        push_init();
        repeat (8) exp_q.push_back(IDLE_FREE);
        for (int i = 0; i < 28; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL none_idle cycle %0d: got %h expected %h", i, obs, e);
            end
            DATA_IN = $urandom;
            RW_IN   = 4'($urandom_range(0, 15));
            RS_IN   = 4'($urandom_range(0, 15));
        end
        set_default_requesters();
    endtask

    task automatic test_gap_restart();
        logic [15:0] e;
        MODE = 4'd1;
        exp_q.push_back(IDLE_FREE);
        exp_q.push_back(ev(1'b0, 1'b0, 8'h01, 4'b0000, 1'b1));
        repeat (4) exp_q.push_back(IDLE_BUSY);
        repeat (2) exp_q.push_back(ev(1'b1, 1'b1, 8'hD3, 4'b1000, 1'b0));
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL gap_restart cycle %0d: got %h expected %h", i, obs, e);
            end
            if (i == 2) MODE = 4'd3;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        logic [15:0] part [$];
        MODE = 4'd0;
        #2 RESET = 1'b0;
        #1 RESET = 1'b1;
        push_init();
        for (int i = 0; i < 11; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        exp_q.delete();
        #2 RESET = 1'b0;
        #1;
        vec_cnt++;
        if (obs !== IDLE_BUSY) begin
            err_cnt++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, IDLE_BUSY);
        end
        #1 RESET = 1'b1;
        push_init();
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs !== e) begin
                err_cnt++;
                $display("FAIL reset_mid_restart cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_init();
        test_pass_data();
        test_mode_switch();
        test_none();
        test_gap_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
